// File: rtl/invader_formation_if.sv
// Kill request channel between collision detection and the formation scheduler.
interface invader_formation_if #(
    parameter int COLS = 8,
    parameter int ROWS = 4
);
    logic                    kill_valid;
    logic [$clog2(COLS)-1:0] kill_col;
    logic [$clog2(ROWS)-1:0] kill_row;
    logic                    kill_hit;

    modport master (output kill_valid, output kill_col, output kill_row, input kill_hit);
    modport slave  (input kill_valid, input kill_col, input kill_row, output kill_hit);
endinterface

// File: rtl/invader_formation_ctrl.sv
// Invader grid scheduler: formation origin, alive mask, march cadence and
// the edge / landing / cleared decisions.
module invader_formation_ctrl #(
    parameter int H_RES           = 640,
    parameter int SCREEN_CORDW    = 16,
    parameter int COLS            = 8,
    parameter int ROWS            = 4,
    parameter int CELL_W          = 48,
    parameter int CELL_H          = 40,
    parameter int SPRITE_W        = 36,
    parameter int SPRITE_H        = 36,
    parameter int STEP_X          = 8,
    parameter int STEP_Y          = 16,
    parameter int START_X         = 32,
    parameter int START_Y         = 48,
    parameter int FRAMES_PER_STEP = 30,
    parameter int MIN_FRAMES      = 4,
    parameter int FLOOR_Y         = 400
) (
    input  logic                              clk_pix,
    input  logic                              rst_n,
    input  logic                              frame,
    input  logic                              en,
    input  logic                              restart,
    invader_formation_if.slave                kill_if,
    output logic [SCREEN_CORDW-1:0]           formation_x,
    output logic [SCREEN_CORDW-1:0]           formation_y,
    output logic [ROWS*COLS-1:0]              alive,
    output logic [$clog2(ROWS*COLS+1)-1:0]    alive_count,
    output logic                              dir_right,
    output logic                              step,
    output logic                              landed,
    output logic                              cleared
);
    localparam int W    = SCREEN_CORDW + 2;
    localparam int CW   = $clog2(COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int NW   = $clog2(ROWS*COLS+1);
    localparam int IW   = $clog2(FRAMES_PER_STEP+1);
    localparam int IDXW = $clog2(ROWS*COLS);

    localparam logic [1:0] MARCH   = 2'd0;
    localparam logic [1:0] DESCEND = 2'd1;
    localparam logic [1:0] LANDED  = 2'd2;
    localparam logic [1:0] CLEARED = 2'd3;

    localparam logic [W-1:0] H_RES_W    = W'(H_RES);
    localparam logic [W-1:0] CELL_W_W   = W'(CELL_W);
    localparam logic [W-1:0] CELL_H_W   = W'(CELL_H);
    localparam logic [W-1:0] SPRITE_W_W = W'(SPRITE_W);
    localparam logic [W-1:0] SPRITE_H_W = W'(SPRITE_H);
    localparam logic [W-1:0] STEP_X_W   = W'(STEP_X);
    localparam logic [W-1:0] STEP_Y_W   = W'(STEP_Y);
    localparam logic [W-1:0] FLOOR_Y_W  = W'(FLOOR_Y);
    localparam logic [IW-1:0] FPS_I     = IW'(FRAMES_PER_STEP);
    localparam logic [IW-1:0] MIN_I     = IW'(MIN_FRAMES);

    logic [SCREEN_CORDW-1:0] x_q, x_d, y_q, y_d;
    logic [ROWS*COLS-1:0]    alive_q, alive_d;
    logic [NW-1:0]           count_q, count_d;
    logic [IW-1:0]           interval_q, interval_d, frame_cnt_q, frame_cnt_d;
    logic [1:0]              state_q, state_d;
    logic                    dir_q, dir_d, step_q, step_d, kill_hit_q, kill_hit_d;
    logic                    landed_q, landed_d, cleared_q, cleared_d;

    logic [COLS-1:0]         col_any;
    logic [ROWS-1:0]         row_any;
    logic [ROWS-1:0]         col_bits [COLS];
    logic [CW-1:0]           lmin, rmax;
    logic [RW-1:0]           bmax;
    logic                    right_edge, left_edge, land_hit;
    logic                    kill_in_range, kill_ok;
    logic [IDXW-1:0]         kill_idx;

    genvar gi, gj;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            for (gj = 0; gj < ROWS; gj++) begin : g_row_bit
                assign col_bits[gi][gj] = alive_q[gj*COLS + gi];
            end
            assign col_any[gi] = |col_bits[gi];
        end
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            assign row_any[gi] = |alive_q[gi*COLS +: COLS];
        end
    endgenerate

    // Extents of the surviving invaders; zero when the mask is empty.
    always_comb begin
        lmin = '0;
        rmax = '0;
        bmax = '0;
        for (int c = COLS-1; c >= 0; c--) if (col_any[c]) lmin = CW'(c);
        for (int c = 0; c < COLS; c++)    if (col_any[c]) rmax = CW'(c);
        for (int r = 0; r < ROWS; r++)    if (row_any[r]) bmax = RW'(r);
    end

    assign right_edge = ({2'b00, x_q} + STEP_X_W + W'(rmax) * CELL_W_W + SPRITE_W_W) > H_RES_W;
    // The second term keeps the origin from wrapping when leading columns are dead.
    assign left_edge  = (({2'b00, x_q} + W'(lmin) * CELL_W_W) < STEP_X_W) ||
                        ({2'b00, x_q} < STEP_X_W);
    assign land_hit   = ({2'b00, y_q} + STEP_Y_W + W'(bmax) * CELL_H_W + SPRITE_H_W) >= FLOOR_Y_W;

    assign kill_in_range = (32'(kill_if.kill_col) < COLS) && (32'(kill_if.kill_row) < ROWS);
    assign kill_idx      = IDXW'(kill_if.kill_row) * IDXW'(COLS) + IDXW'(kill_if.kill_col);
    assign kill_ok       = kill_if.kill_valid && kill_in_range && alive_q[kill_idx] &&
                           (state_q == MARCH || state_q == DESCEND);

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        alive_d     = alive_q;
        count_d     = count_q;
        interval_d  = interval_q;
        frame_cnt_d = frame_cnt_q;
        state_d     = state_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        kill_hit_d  = 1'b0;
        landed_d    = landed_q;
        cleared_d   = cleared_q;

        if (restart) begin
            x_d         = SCREEN_CORDW'(START_X);
            y_d         = SCREEN_CORDW'(START_Y);
            alive_d     = '1;
            count_d     = NW'(ROWS*COLS);
            interval_d  = FPS_I;
            frame_cnt_d = '0;
            state_d     = MARCH;
            dir_d       = 1'b1;
            landed_d    = 1'b0;
            cleared_d   = 1'b0;
        end else begin
            if (kill_ok) begin
                alive_d[kill_idx] = 1'b0;
                count_d           = count_q - NW'(1);
                kill_hit_d        = 1'b1;
                if (interval_q > MIN_I) interval_d = interval_q - IW'(1);
            end
            case (state_q)
                MARCH: begin
                    if (alive_q == '0) begin
                        state_d   = CLEARED;
                        cleared_d = 1'b1;
                    end else if (en && frame) begin
                        if (frame_cnt_q >= interval_q - IW'(1)) begin
                            frame_cnt_d = '0;
                            if (dir_q ? right_edge : left_edge) begin
                                state_d = DESCEND;
                            end else begin
                                step_d = 1'b1;
                                x_d    = dir_q ? x_q + SCREEN_CORDW'(STEP_X)
                                               : x_q - SCREEN_CORDW'(STEP_X);
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + IW'(1);
                        end
                    end
                end
                DESCEND: begin
                    if (alive_q == '0) begin
                        state_d   = CLEARED;
                        cleared_d = 1'b1;
                    end else begin
                        y_d    = y_q + SCREEN_CORDW'(STEP_Y);
                        dir_d  = ~dir_q;
                        step_d = 1'b1;
                        // A kill emptying the grid right now lets cleared take over next cycle.
                        if (land_hit && !(kill_ok && count_q == NW'(1))) begin
                            state_d  = LANDED;
                            landed_d = 1'b1;
                        end else begin
                            state_d = MARCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= SCREEN_CORDW'(START_X);
            y_q         <= SCREEN_CORDW'(START_Y);
            alive_q     <= '1;
            count_q     <= NW'(ROWS*COLS);
            interval_q  <= FPS_I;
            frame_cnt_q <= '0;
            state_q     <= MARCH;
            dir_q       <= 1'b1;
            step_q      <= 1'b0;
            kill_hit_q  <= 1'b0;
            landed_q    <= 1'b0;
            cleared_q   <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            alive_q     <= alive_d;
            count_q     <= count_d;
            interval_q  <= interval_d;
            frame_cnt_q <= frame_cnt_d;
            state_q     <= state_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            kill_hit_q  <= kill_hit_d;
            landed_q    <= landed_d;
            cleared_q   <= cleared_d;
        end
    end

    assign formation_x      = x_q;
    assign formation_y      = y_q;
    assign alive            = alive_q;
    assign alive_count      = count_q;
    assign dir_right        = dir_q;
    assign step             = step_q;
    assign landed           = landed_q;
    assign cleared          = cleared_q;
    assign kill_if.kill_hit = kill_hit_q;
endmodule

// File: tb/tb_invader_formation_ctrl.sv
// Directed bench for invader_formation_ctrl: cadence, edges, kills, landing,
// restart, clearing and asynchronous reset.
module tb_invader_formation_ctrl;
    logic        clk_pix = 1'b0;
    logic        rst_n   = 1'b0;
    logic        frame   = 1'b0;
    logic        en      = 1'b0;
    logic        restart = 1'b0;
    logic [15:0] formation_x, formation_y;
    logic [31:0] alive;
    logic [5:0]  alive_count;
    logic        dir_right, step, landed, cleared;

    invader_formation_if #(.COLS(8), .ROWS(4)) kif ();

    invader_formation_ctrl dut (
        .clk_pix     (clk_pix),
        .rst_n       (rst_n),
        .frame       (frame),
        .en          (en),
        .restart     (restart),
        .kill_if     (kif),
        .formation_x (formation_x),
        .formation_y (formation_y),
        .alive       (alive),
        .alive_count (alive_count),
        .dir_right   (dir_right),
        .step        (step),
        .landed      (landed),
        .cleared     (cleared)
    );

    always #5 clk_pix = ~clk_pix;

    int          total = 0;
    int          bad   = 0;
    int          ex, ey;
    bit          edir, elanded;
    logic [31:0] emask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    function automatic int f_lmin(input logic [31:0] m);
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 4; r++)
                if (m[r*8+c]) return c;
        return 0;
    endfunction

    function automatic int f_rmax(input logic [31:0] m);
        for (int c = 7; c >= 0; c--)
            for (int r = 0; r < 4; r++)
                if (m[r*8+c]) return c;
        return 0;
    endfunction

    function automatic int f_bmax(input logic [31:0] m);
        for (int r = 3; r >= 0; r--)
            if (m[r*8 +: 8] != 8'h00) return r;
        return 0;
    endfunction

    task automatic model_reset();
        ex = 32; ey = 48; edir = 1'b1; elanded = 1'b0; emask = '1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_x"},        32'(formation_x), 32);
        chk({tag, "_y"},        32'(formation_y), 48);
        chk({tag, "_alive"},    alive, 32'hFFFF_FFFF);
        chk({tag, "_count"},    32'(alive_count), 32);
        chk({tag, "_dir"},      32'(dir_right), 1);
        chk({tag, "_step"},     32'(step), 0);
        chk({tag, "_kill_hit"}, 32'(kif.kill_hit), 0);
        chk({tag, "_landed"},   32'(landed), 0);
        chk({tag, "_cleared"},  32'(cleared), 0);
    endtask

    task automatic kill(input int c, input int r, input bit exp_hit);
        kif.kill_valid = 1'b1;
        kif.kill_col   = 3'(c);
        kif.kill_row   = 2'(r);
        tick();
        kif.kill_valid = 1'b0;
        chk("kill_hit", 32'(kif.kill_hit), 32'(exp_hit));
        if (exp_hit) emask[r*8+c] = 1'b0;
        chk("kill_alive", alive, emask);
        chk("kill_count", 32'(alive_count), 32'($countones(emask)));
    endtask

    // Pulse frames (each followed by an idle cycle) until a move shows up,
    // then check it against the pre-kill extents. Optional kill on frame e_int.
    task automatic one_step(input bit kill_en, input int kc, input int kr, input int e_int);
        int          nf;
        bit          s1, s2, kh, got, edge_hit;
        logic [31:0] pre;
        nf = 0; got = 0; s1 = 0; s2 = 0; kh = 0; pre = emask;
        while (!got && nf < 64) begin
            frame = 1'b1;
            if (kill_en && nf == e_int - 1) begin
                kif.kill_valid = 1'b1;
                kif.kill_col   = 3'(kc);
                kif.kill_row   = 2'(kr);
            end
            tick();
            frame = 1'b0;
            kif.kill_valid = 1'b0;
            s1 = step;
            kh = kif.kill_hit;
            tick();
            s2 = step;
            nf++;
            got = s1 || s2;
        end
        chk("step_seen", 32'(got), 1);
        if (e_int > 0) chk("interval", nf, e_int);
        if (edir) edge_hit = (ex + 8 + f_rmax(pre)*48 + 36) > 640;
        else      edge_hit = (ex + f_lmin(pre)*48) < 8;
        if (kill_en) begin
            chk("step_kill_hit", 32'(kh), 1);
            emask[kr*8+kc] = 1'b0;
        end
        if (edge_hit) begin
            chk("desc_s1", 32'(s1), 0);
            chk("desc_s2", 32'(s2), 1);
            ey      = ey + 16;
            edir    = !edir;
            elanded = (ey + f_bmax(emask)*40 + 36) >= 400;
        end else begin
            chk("move_s1", 32'(s1), 1);
            chk("move_s2", 32'(s2), 0);
            ex = edir ? ex + 8 : ex - 8;
        end
        chk("step_x", 32'(formation_x), ex);
        chk("step_y", 32'(formation_y), ey);
        chk("step_dir", 32'(dir_right), 32'(edir));
        chk("step_landed", 32'(landed), 32'(elanded));
    endtask

    initial begin
        int n;
        bit stepped;
        kif.kill_valid = 1'b0;
        kif.kill_col   = '0;
        kif.kill_row   = '0;
        model_reset();
        tick(); tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        en = 1'b1;

        // First step after the 30th frame pulse
        one_step(0, 0, 0, 30);
        chk("first_x", 32'(formation_x), 40);
        for (int i = 0; i < 28; i++) one_step(0, 0, 0, 30);
        chk("x_264", 32'(formation_x), 264);
        one_step(0, 0, 0, 30);
        chk("desc1_y", 32'(formation_y), 64);
        chk("desc1_dir", 32'(dir_right), 0);
        chk("desc1_x", 32'(formation_x), 264);

        // Kill column 7, then a dead cell; interval must become 26
        for (int r = 0; r < 4; r++) kill(7, r, 1);
        kill(7, 0, 0);
        chk("count_28", 32'(alive_count), 28);
        one_step(0, 0, 0, 0);
        one_step(0, 0, 0, 26);

        // Shrink interval to the floor and one kill beyond it
        for (int c = 6; c >= 2; c--)
            for (int r = 0; r < 4; r++) kill(c, r, 1);
        kill(1, 0, 1);
        kill(1, 1, 1);
        kill(1, 2, 1);
        one_step(0, 0, 0, 0);
        one_step(0, 0, 0, 4);

        // March to the right edge (Rmax=1) and kill column 1 on that very step
        n = 0;
        while (!(edir && (ex + 8 + f_rmax(emask)*48 + 36) > 640) && n < 500) begin
            one_step(0, 0, 0, 4);
            n++;
        end
        chk("x_before_kill_step", 32'(formation_x), 552);
        one_step(1, 1, 3, 4);
        chk("kill_step_x", 32'(formation_x), 552);
        chk("kill_step_dir", 32'(dir_right), 0);

        // Keep descending until the formation lands
        n = 0;
        while (!elanded && n < 3000) begin
            one_step(0, 0, 0, 4);
            n++;
        end
        chk("landed", 32'(landed), 1);
        chk("landed_y", 32'(formation_y), 256);
        stepped = 0;
        for (int i = 0; i < 10; i++) begin
            frame = 1'b1; tick(); frame = 1'b0;
            if (step) stepped = 1;
            tick();
            if (step) stepped = 1;
        end
        chk("landed_no_step", 32'(stepped), 0);
        kill(0, 0, 0);

        // Restart wins over a same-cycle frame and kill
        restart = 1'b1; frame = 1'b1;
        kif.kill_valid = 1'b1; kif.kill_col = 3'd0; kif.kill_row = 2'd0;
        tick();
        restart = 1'b0; frame = 1'b0; kif.kill_valid = 1'b0;
        check_reset_vals("restart");
        model_reset();
        one_step(0, 0, 0, 30);
        chk("restart_first_x", 32'(formation_x), 40);

        // Kill every invader
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) kill(c, r, 1);
        chk("cleared_at_hit", 32'(cleared), 0);
        tick();
        chk("cleared", 32'(cleared), 1);
        chk("cleared_landed", 32'(landed), 0);
        stepped = 0;
        for (int i = 0; i < 40; i++) begin
            frame = 1'b1; tick(); frame = 1'b0;
            if (step) stepped = 1;
            tick();
            if (step) stepped = 1;
        end
        chk("cleared_no_step", 32'(stepped), 0);

        // March to the descent decision, then pull reset asynchronously
        restart = 1'b1; tick(); restart = 1'b0;
        model_reset();
        for (int i = 0; i < 29; i++) one_step(0, 0, 0, 30);
        chk("pre_desc_x", 32'(formation_x), 264);
        for (int i = 0; i < 30; i++) begin
            frame = 1'b1; tick(); frame = 1'b0;
        end
        chk("desc_pending_step", 32'(step), 0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_vals("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
